// File: rtl/stream_demux_1_to_2_pkg.sv
// Shared definitions for the 1:2 packet stream demultiplexer: FSM state
// encoding, destination codes and the destination decode helper.
package stream_demux_1_to_2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PKT_A = 2'd1,
        ST_PKT_B = 2'd2
    } state_e;

    localparam logic DEST_A = 1'b0;
    localparam logic DEST_B = 1'b1;

    // Between packets the source chooses the destination; inside a packet
    // the destination is locked to the one captured on the first beat.
    function automatic logic state_dest(input state_e st, input logic sel);
        logic dest;
        case (st)
            ST_PKT_A: dest = DEST_A;
            ST_PKT_B: dest = DEST_B;
            default:  dest = sel;
        endcase
        return dest;
    endfunction

endpackage

// File: rtl/stream_demux_1_to_2_stream_out_stage.sv
// One-entry valid/ready register slice. The upstream may load it whenever
// it is free, including the cycle in which the held beat drains.
module stream_out_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             free,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             last_q, last_d;
    logic             valid_q, valid_d;

    assign free = !valid_q || out_ready;

    always_comb begin
        data_d  = data_q;
        last_d  = last_q;
        valid_d = valid_q;
        if (load) begin
            data_d  = in_data;
            last_d  = in_last;
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_last  = last_q;
    assign out_valid = valid_q;

endmodule

// File: rtl/stream_demux_1_to_2.sv
// Routes whole packets from one valid/ready stream to output A or B and
// counts the packets completed on each output.
module stream_demux_1_to_2
    import stream_demux_1_to_2_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_sel,
    input  logic             s_last,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_last,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_last,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
    logic             dest;
    logic             accept;
    logic             a_free, b_free;
    logic             a_load, b_load;

    assign dest    = state_dest(state_q, s_sel);
    assign s_ready = (dest == DEST_B) ? b_free : a_free;
    assign accept  = s_valid && s_ready;
    assign a_load  = accept && (dest == DEST_A);
    assign b_load  = accept && (dest == DEST_B);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && !s_last) begin
                    state_d = (s_sel == DEST_B) ? ST_PKT_B : ST_PKT_A;
                end
            end
            ST_PKT_A, ST_PKT_B: begin
                if (accept && s_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A packet counts as delivered only when its last beat leaves the stage.
    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (a_valid && a_ready && a_last) begin
            cnt_a_d = cnt_a_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (b_valid && b_ready && b_last) begin
            cnt_b_d = cnt_b_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    stream_out_stage #(.WIDTH(WIDTH)) u_stage_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (a_load),
        .in_data   (s_data),
        .in_last   (s_last),
        .free      (a_free),
        .out_data  (a_data),
        .out_last  (a_last),
        .out_valid (a_valid),
        .out_ready (a_ready)
    );

    stream_out_stage #(.WIDTH(WIDTH)) u_stage_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (b_load),
        .in_data   (s_data),
        .in_last   (s_last),
        .free      (b_free),
        .out_data  (b_data),
        .out_last  (b_last),
        .out_valid (b_valid),
        .out_ready (b_ready)
    );

    assign cnt_a = cnt_a_q;
    assign cnt_b = cnt_b_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_stream_demux_1_to_2.sv
// Directed bench for stream_demux_1_to_2; a second instance with 2-bit
// counters shares the stimulus to exercise counter wrap.
module tb_stream_demux_1_to_2;

    logic        clk;
    logic        rst_n;
    logic [7:0]  s_data;
    logic        s_sel, s_last, s_valid, s_ready;
    logic [7:0]  a_data, b_data;
    logic        a_last, a_valid, a_ready;
    logic        b_last, b_valid, b_ready;
    logic [15:0] cnt_a, cnt_b;
    logic        busy;

    logic        w_s_ready;
    logic [7:0]  w_a_data, w_b_data;
    logic        w_a_last, w_a_valid, w_b_last, w_b_valid, w_busy;
    logic [1:0]  w_cnt_a, w_cnt_b;

    int tests_run = 0;
    int tests_failed = 0;

    stream_demux_1_to_2 #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_sel(s_sel), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
        .a_data(a_data), .a_last(a_last), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_last(b_last), .b_valid(b_valid), .b_ready(b_ready),
        .cnt_a(cnt_a), .cnt_b(cnt_b), .busy(busy)
    );

    stream_demux_1_to_2 #(.WIDTH(8), .CNT_W(2)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_sel(s_sel), .s_last(s_last), .s_valid(s_valid), .s_ready(w_s_ready),
        .a_data(w_a_data), .a_last(w_a_last), .a_valid(w_a_valid), .a_ready(a_ready),
        .b_data(w_b_data), .b_last(w_b_last), .b_valid(w_b_valid), .b_ready(b_ready),
        .cnt_a(w_cnt_a), .cnt_b(w_cnt_b), .busy(w_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Offer one beat, wait (bounded) for s_ready, then let it be accepted.
    // Returns the number of cycles spent stalled before acceptance.
    task automatic send(input logic [7:0] d, input logic sel, input logic last, output int stalls);
        s_data  = d;
        s_sel   = sel;
        s_last  = last;
        s_valid = 1'b1;
        stalls  = 0;
        @(negedge clk);
        while (!s_ready && stalls < 50) begin
            stalls++;
            @(negedge clk);
        end
        if (!s_ready) check_val("send_timeout", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int st;
        rst_n = 1'b0;
        s_data = '0; s_sel = 1'b0; s_last = 1'b0; s_valid = 1'b0;
        a_ready = 1'b1; b_ready = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_a_valid", 32'(a_valid), 32'd0);
        check_val("rst_b_valid", 32'(b_valid), 32'd0);
        check_val("rst_a_data", 32'(a_data), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_cnt_a", 32'(cnt_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset in the middle of a B packet with a beat pending on B
        send(8'h99, 1'b1, 1'b0, st);
        check_val("pktb_busy", 32'(busy), 32'd1);
        check_val("pktb_b_valid", 32'(b_valid), 32'd1);
        check_val("pktb_b_data", 32'(b_data), 32'h99);
        rst_n = 1'b0;
        #1;
        check_val("arst_b_valid", 32'(b_valid), 32'd0);
        check_val("arst_b_data", 32'(b_data), 32'd0);
        check_val("arst_busy", 32'(busy), 32'd0);
        check_val("arst_cnt_b", 32'(cnt_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 3-beat packet to A
        a_ready = 1'b1; b_ready = 1'b1;
        send(8'd11, 1'b0, 1'b0, st);
        check_val("a3_d0", 32'(a_data), 32'd11);
        check_val("a3_v0", 32'(a_valid), 32'd1);
        check_val("a3_busy", 32'(busy), 32'd1);
        send(8'd22, 1'b0, 1'b0, st);
        check_val("a3_d1", 32'(a_data), 32'd22);
        check_val("a3_stall1", 32'(st), 32'd0);
        send(8'd33, 1'b0, 1'b1, st);
        check_val("a3_d2", 32'(a_data), 32'd33);
        check_val("a3_last", 32'(a_last), 32'd1);
        check_val("a3_b_valid", 32'(b_valid), 32'd0);
        check_val("a3_busy_end", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check_val("a3_cnt_a", 32'(cnt_a), 32'd1);
        check_val("a3_a_drained", 32'(a_valid), 32'd0);

        // Packet to B with s_sel toggled mid-packet
        send(8'h61, 1'b1, 1'b0, st);
        check_val("bsel_d0", 32'(b_data), 32'h61);
        send(8'h62, 1'b0, 1'b0, st);
        check_val("bsel_d1", 32'(b_data), 32'h62);
        check_val("bsel_a_valid1", 32'(a_valid), 32'd0);
        send(8'h63, 1'b0, 1'b1, st);
        check_val("bsel_d2", 32'(b_data), 32'h63);
        check_val("bsel_a_valid2", 32'(a_valid), 32'd0);
        @(posedge clk);
        #1;
        check_val("bsel_cnt_b", 32'(cnt_b), 32'd1);
        check_val("bsel_cnt_a", 32'(cnt_a), 32'd1);

        // Backpressure on B for 4 cycles
        b_ready = 1'b0;
        send(8'h41, 1'b1, 1'b0, st);
        s_data = 8'h42; s_sel = 1'b1; s_last = 1'b0; s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val($sformatf("bp_s_ready_%0d", i), 32'(s_ready), 32'd0);
            check_val($sformatf("bp_b_hold_%0d", i), 32'(b_data), 32'h41);
            @(posedge clk);
            #1;
        end
        b_ready = 1'b1;
        @(negedge clk);
        check_val("bp_resume_ready", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        check_val("bp_d1", 32'(b_data), 32'h42);
        check_val("bp_v1", 32'(b_valid), 32'd1);
        send(8'h43, 1'b1, 1'b1, st);
        check_val("bp_d2", 32'(b_data), 32'h43);
        @(posedge clk);
        #1;
        check_val("bp_cnt_b", 32'(cnt_b), 32'd2);
        check_val("bp_b_drained", 32'(b_valid), 32'd0);

        // Back-to-back single-beat packets A, B, A
        do_reset();
        send(8'h51, 1'b0, 1'b1, st);
        check_val("sb_a0", 32'(a_data), 32'h51);
        check_val("sb_busy0", 32'(busy), 32'd0);
        send(8'h52, 1'b1, 1'b1, st);
        check_val("sb_stall1", 32'(st), 32'd0);
        check_val("sb_b1", 32'(b_data), 32'h52);
        check_val("sb_a_drop", 32'(a_valid), 32'd0);
        check_val("sb_busy1", 32'(busy), 32'd0);
        send(8'h53, 1'b0, 1'b1, st);
        check_val("sb_stall2", 32'(st), 32'd0);
        check_val("sb_a2", 32'(a_data), 32'h53);
        @(posedge clk);
        #1;
        check_val("sb_cnt_a", 32'(cnt_a), 32'd2);
        check_val("sb_cnt_b", 32'(cnt_b), 32'd1);

        // Counter wrap on the 2-bit instance: 5 packets to A
        do_reset();
        send(8'h01, 1'b0, 1'b1, st);
        send(8'h02, 1'b0, 1'b1, st);
        check_val("wrap_1", 32'(w_cnt_a), 32'd1);
        send(8'h03, 1'b0, 1'b1, st);
        check_val("wrap_2", 32'(w_cnt_a), 32'd2);
        send(8'h04, 1'b0, 1'b1, st);
        check_val("wrap_3", 32'(w_cnt_a), 32'd3);
        send(8'h05, 1'b0, 1'b1, st);
        check_val("wrap_0", 32'(w_cnt_a), 32'd0);
        @(posedge clk);
        #1;
        check_val("wrap_1b", 32'(w_cnt_a), 32'd1);
        check_val("nowrap_5", 32'(cnt_a), 32'd5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
